// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared types and constants for the arbitro_rr arbiter.
//   mode_e  : per-cycle arbitration mode carried on e[1:0]
//   state_e : arbiter control state
//   N_REQ   : number of requesters sharing the result path
package arbitro_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,  // p3 > p2 > p1 > p0
        MODE_RR    = 2'b01,  // rotating, hold limited
        MODE_LOCK  = 2'b10,  // rotating, owner keeps grant until it drops
        MODE_OFF   = 2'b11   // no grants
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/arbitro_pick.sv
// arbitro_pick: combinational winner selection.
//   p       in  N_REQ  request levels
//   e       in  mode   MODE_FIXED -> highest index wins; otherwise the first
//                      set bit found searching upward from last+1 (wrapping)
//   last    in  2      previous rotating winner
//   winner  out 2      selected index (0 when no request)
//   any_req out 1      at least one request present
module arbitro_pick
    import arbitro_pkg::*;
(
    input  logic [N_REQ-1:0] p,
    input  mode_e            e,
    input  logic [1:0]       last,
    output logic [1:0]       winner,
    output logic             any_req
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        winner  = '0;
        any_req = |p;
        idx     = '0;
        found   = 1'b0;
        if (e == MODE_FIXED) begin
            // Ascending scan: the last hit (highest index) is kept.
            for (int i = 0; i < N_REQ; i++) begin
                if (p[i]) winner = 2'(i);
            end
        end else begin
            // last+1 .. last+4; the 2-bit add wraps 3->0, and the final step
            // lands on last itself so the previous owner is considered last.
            for (int k = 1; k <= N_REQ; k++) begin
                idx = last + 2'(k);
                if (!found && p[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// arbitro_rr: registered four-way arbiter in front of the shared 2-bit path.
//   clk       in  1       rising-edge clock
//   rst_n     in  1       asynchronous active-low reset
//   e         in  2       mode (00 fixed, 01 round-robin, 10 locked RR, 11 off)
//   p         in  4       request levels
//   y         out 2       granted index
//   gnt_valid out 1       y holds a live grant
//   gnt       out 4       one-hot grant, zero when not valid
//   hold_cnt  out HOLD_W  cycles the current owner has held the grant
//   starve    out 4       (ARB_STARVE_EN only) requester waited >= 4*MAX_HOLD
// Optional feature macro: ARB_STARVE_EN adds per-requester wait counters and
// lets a starving requester override the mode pick in IDLE.
module arbitro_rr
    import arbitro_pkg::*;
#(
    parameter  int MAX_HOLD = 8,
    localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        e,
    input  logic [N_REQ-1:0]  p,
    output logic [1:0]        y,
    output logic              gnt_valid,
    output logic [N_REQ-1:0]  gnt,
`ifdef ARB_STARVE_EN
    output logic [HOLD_W-1:0] hold_cnt,
    output logic [N_REQ-1:0]  starve
`else
    output logic [HOLD_W-1:0] hold_cnt
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    mode_e             mode;
    state_e            state, state_n;
    logic [1:0]        last, last_n;
    logic [1:0]        y_n;
    logic              vld_n;
    logic [N_REQ-1:0]  gnt_n;
    logic [HOLD_W-1:0] hold_n;
    logic [1:0]        pick_y;
    logic              any_req;
    logic [1:0]        sel;

    assign mode = mode_e'(e);

    arbitro_pick u_pick (
        .p       (p),
        .e       (mode),
        .last    (last),
        .winner  (pick_y),
        .any_req (any_req)
    );

`ifdef ARB_STARVE_EN
    localparam int STARVE_TH = 4 * MAX_HOLD;

    logic [N_REQ-1:0][7:0] wait_cnt;
    logic [N_REQ-1:0]      starve_req;

    always_comb begin
        starve = '0;
        for (int i = 0; i < N_REQ; i++) begin
            starve[i] = (int'(wait_cnt[i]) >= STARVE_TH);
        end
    end

    // A flag can outlive the request by one cycle; only live requests override.
    assign starve_req = starve & p;

    always_comb begin
        sel = pick_y;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (starve_req[i]) sel = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!p[i] || gnt[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != 8'hFF)
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
            end
        end
    end
`else
    assign sel = pick_y;
`endif

    always_comb begin
        state_n = state;
        last_n  = last;
        y_n     = y;
        vld_n   = gnt_valid;
        gnt_n   = gnt;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (mode != MODE_OFF && any_req) begin
                    state_n = GRANT;
                    y_n     = sel;
                    vld_n   = 1'b1;
                    gnt_n   = N_REQ'(1) << sel;
                    hold_n  = HOLD_W'(1);
                    if (mode != MODE_FIXED) last_n = sel;
                end
            end
            GRANT: begin
                // Abort, owner release and hold limit all fall back to IDLE,
                // which doubles as the one-cycle bus turnaround.
                if (mode == MODE_OFF || !p[y] ||
                    (mode != MODE_LOCK && hold_cnt == HOLD_MAX)) begin
                    state_n = IDLE;
                    vld_n   = 1'b0;
                    gnt_n   = '0;
                    hold_n  = '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 2'd3;
            y         <= '0;
            gnt_valid <= 1'b0;
            gnt       <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            y         <= y_n;
            gnt_valid <= vld_n;
            gnt       <= gnt_n;
            hold_cnt  <= hold_n;
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: directed scoreboard bench for arbitro_rr (MAX_HOLD=8).
module tb_arbitro_rr;
    import arbitro_pkg::*;

    localparam int MH = 8;
    localparam int HW = $clog2(MH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    e;
    logic [3:0]    p;
    logic [1:0]    y;
    logic          gnt_valid;
    logic [3:0]    gnt;
    logic [HW-1:0] hold_cnt;
`ifdef ARB_STARVE_EN
    logic [3:0]    starve;
`endif

    arbitro_rr #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .e         (e),
        .p         (p),
        .y         (y),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
`ifdef ARB_STARVE_EN
        .hold_cnt  (hold_cnt),
        .starve    (starve)
`else
        .hold_cnt  (hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       chk_y;
        logic [1:0] y;
        int         hc;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input logic v, input logic cy, input logic [1:0] yy,
                        input int hc, input string tag);
        exp_t x;
        x.v = v; x.chk_y = cy; x.y = yy; x.hc = hc; x.tag = tag;
        sbq.push_back(x);
    endtask

    task automatic check_out();
        exp_t       x;
        logic [3:0] eg;
        total++;
        assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty got=0 exp=1");
        end
        if (sbq.size() != 0) begin
            x  = sbq.pop_front();
            eg = x.v ? (4'b0001 << x.y) : 4'b0000;
            total++;
            assert (gnt_valid === x.v) else begin
                bad++;
                $error("FAIL %s gnt_valid got=%0b exp=%0b", x.tag, gnt_valid, x.v);
            end
            total++;
            assert (gnt === eg) else begin
                bad++;
                $error("FAIL %s gnt got=%b exp=%b", x.tag, gnt, eg);
            end
            total++;
            assert (hold_cnt === HW'(x.hc)) else begin
                bad++;
                $error("FAIL %s hold_cnt got=%0d exp=%0d", x.tag, hold_cnt, x.hc);
            end
            if (x.chk_y) begin
                total++;
                assert (y === x.y) else begin
                    bad++;
                    $error("FAIL %s y got=%0d exp=%0d", x.tag, y, x.y);
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, record what must appear after the edge.
    task automatic cyc(input logic [1:0] ee, input logic [3:0] pp, input logic v,
                       input logic [1:0] yy, input int hc, input string tag);
        e = ee;
        p = pp;
        push(v, v, yy, hc, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse(input string tag);
        #3;
        p     = 4'b0000;
        rst_n = 1'b0;
        push(1'b0, 1'b1, 2'd0, 0, tag);
        #1;
        check_out();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        e     = 2'b00;
        p     = 4'b0000;
        #3;
        push(1'b0, 1'b1, 2'd0, 0, "reset");
        check_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed priority: highest index wins, one IDLE gap after release.
        cyc(2'b00, 4'b1010, 1, 2'd3, 1, "fix_p3");
        cyc(2'b00, 4'b0010, 0, 2'd0, 0, "fix_drop3");
        cyc(2'b00, 4'b0010, 1, 2'd1, 1, "fix_p1");
        cyc(2'b00, 4'b1000, 0, 2'd0, 0, "fix_drop1");
        for (int h = 1; h <= MH; h++) cyc(2'b00, 4'b1000, 1, 2'd3, h, "fix_hold");
        cyc(2'b00, 4'b1000, 0, 2'd0, 0, "fix_limit");
        cyc(2'b00, 4'b1000, 1, 2'd3, 1, "fix_rewin");
        cyc(2'b00, 4'b0000, 0, 2'd0, 0, "fix_release");
        cyc(2'b00, 4'b0000, 0, 2'd0, 0, "fix_idle");

        // Round-robin with all requesting: 0,1,2,3,0, each MH cycles + gap.
        for (int k = 0; k < 5; k++) begin
            for (int h = 1; h <= MH; h++) cyc(2'b01, 4'b1111, 1, 2'(k % 4), h, "rr_hold");
            cyc(2'b01, 4'b1111, 0, 2'd0, 0, "rr_gap");
        end

        // Mode change mid-grant does not move it; 11 aborts and blocks.
        cyc(2'b01, 4'b0100, 1, 2'd2, 1, "ab_grant");
        cyc(2'b00, 4'b1111, 1, 2'd2, 2, "ab_modechg");
        cyc(2'b01, 4'b0100, 1, 2'd2, 3, "ab_other_drop");
        cyc(2'b11, 4'b0100, 0, 2'd0, 0, "ab_off");
        for (int i = 0; i < 3; i++) cyc(2'b11, 4'b1111, 0, 2'd0, 0, "ab_off_block");
        cyc(2'b01, 4'b0000, 0, 2'd0, 0, "ab_idle");

        // Locked RR: no hold limit, counter saturates.
        rst_pulse("rst_idle");
        for (int i = 1; i <= 40; i++)
            cyc(2'b10, 4'b0011, 1, 2'd0, (i < MH) ? i : MH, "lock_hold");
        cyc(2'b10, 4'b0010, 0, 2'd0, 0, "lock_drop0");
        cyc(2'b10, 4'b0010, 1, 2'd1, 1, "lock_p1");
        cyc(2'b10, 4'b0010, 1, 2'd1, 2, "lock_p1b");

        // Reset mid-grant clears outputs without waiting for an edge.
        rst_pulse("rst_mid");
        cyc(2'b01, 4'b1111, 1, 2'd0, 1, "rst_rr0");
        cyc(2'b01, 4'b0000, 0, 2'd0, 0, "rst_rr_drop");

`ifdef ARB_STARVE_EN
        rst_pulse("rst_starve");
        for (int b = 0; b < 4; b++) begin
            for (int h = 1; h <= MH; h++) cyc(2'b00, 4'b1001, 1, 2'd3, h, "stv_p3");
            cyc(2'b00, 4'b1001, 0, 2'd0, 0, "stv_gap");
            if (b == 0) begin
                total++;
                assert (starve === 4'b0000) else begin
                    bad++;
                    $error("FAIL stv_early starve got=%b exp=0000", starve);
                end
            end
        end
        total++;
        assert (starve === 4'b0001) else begin
            bad++;
            $error("FAIL stv_flag starve got=%b exp=0001", starve);
        end
        cyc(2'b00, 4'b1001, 1, 2'd0, 1, "stv_win");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
